// File: rtl/uart_frame_ser_if.sv
// uart_frame_ser_if
//   Bundles the frame request / byte strobe signals of uart_frame_ser.
//   master : frame requester plus downstream UART model (drives START, LEN,
//            DATA_IN, TX_READY; observes the strobe/status outputs)
//   slave  : the serializer itself
//   Signals:
//     START, LEN, DATA_IN : frame request, byte count, payload (byte 0 in MSBs)
//     TX_READY            : downstream transmitter can take a byte
//     START_OUT, DATA_OUT : one-cycle byte strobe and its byte
//     BUSY, DONE, LEN_ERR : frame in progress, frame finished, request rejected
interface uart_frame_ser_if #(
  parameter int MAX_BYTES = 12,
  parameter int LEN_W     = 4
);
  logic                   START;
  logic [LEN_W-1:0]       LEN;
  logic [8*MAX_BYTES-1:0] DATA_IN;
  logic                   TX_READY;
  logic                   START_OUT;
  logic [7:0]             DATA_OUT;
  logic                   BUSY;
  logic                   DONE;
  logic                   LEN_ERR;

  modport master (
    output START, LEN, DATA_IN, TX_READY,
    input  START_OUT, DATA_OUT, BUSY, DONE, LEN_ERR
  );

  modport slave (
    input  START, LEN, DATA_IN, TX_READY,
    output START_OUT, DATA_OUT, BUSY, DONE, LEN_ERR
  );
endinterface

// File: rtl/uart_frame_ser.sv
// uart_frame_ser
//   Serializes a latched payload of 1..MAX_BYTES bytes into one-cycle byte
//   strobes for a UART byte transmitter, spacing strobes GAP_CYCLES+1 clocks
//   apart and stalling while the transmitter is not ready. All outputs are
//   registered.
//   Ports:
//     CLK  : clock, rising edge
//     RST  : synchronous active-high reset
//     bus  : uart_frame_ser_if.slave (START/LEN/DATA_IN/TX_READY in,
//            START_OUT/DATA_OUT/BUSY/DONE/LEN_ERR out)
//   Build option:
//     UART_FRAME_SER_CHKSUM_EN : when defined, appends one extra byte holding
//     the XOR of all payload bytes, followed by a full gap, before DONE.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for START; validates LEN
//   SEND  | waiting for TX_READY, then strobes the current top byte
//   GAP   | inter-byte timer counting down to 0
//   CHK   | (checksum build only) waiting for TX_READY to strobe the XOR
//   STOP  | first cycle raises DONE, second cycle drops BUSY and returns
module uart_frame_ser #(
  parameter int MAX_BYTES  = 12,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 4330
) (
  input  logic            CLK,
  input  logic            RST,
  uart_frame_ser_if.slave bus
);

  localparam int BUF_W = 8 * MAX_BYTES;
  // sent count must reach MAX_BYTES+1 when the checksum byte is included
  localparam int CNT_W = $clog2(MAX_BYTES + 2);
  localparam int TMR_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    GAP  = 3'd2,
`ifdef UART_FRAME_SER_CHKSUM_EN
    CHK  = 3'd3,
`endif
    STOP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              start_out_q, start_out_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              len_err_q, len_err_d;
`ifdef UART_FRAME_SER_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      start_out_q <= 1'b0;
      data_out_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
`ifdef UART_FRAME_SER_CHKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      start_out_q <= start_out_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      len_err_q   <= len_err_d;
`ifdef UART_FRAME_SER_CHKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    start_out_d = 1'b0;
    data_out_d  = data_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    len_err_d   = 1'b0;
`ifdef UART_FRAME_SER_CHKSUM_EN
    chk_d       = chk_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if ((bus.LEN != '0) && (bus.LEN <= LEN_MAX)) begin
            buf_d   = bus.DATA_IN;
            len_d   = CNT_W'(bus.LEN);
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SEND;
`ifdef UART_FRAME_SER_CHKSUM_EN
            chk_d   = '0;
`endif
          end else begin
            len_err_d = 1'b1;
          end
        end
      end

      SEND: begin
        if (bus.TX_READY) begin
          start_out_d = 1'b1;
          data_out_d  = buf_q[BUF_W-1 -: 8];
          buf_d       = buf_q << 8;
          cnt_d       = cnt_q + CNT_W'(1);
          tmr_d       = GAP_LOAD;
          state_d     = GAP;
`ifdef UART_FRAME_SER_CHKSUM_EN
          chk_d       = chk_q ^ buf_q[BUF_W-1 -: 8];
`endif
        end
      end

      GAP: begin
        if (tmr_q == '0) begin
          if (cnt_q < len_q) begin
            state_d = SEND;
`ifdef UART_FRAME_SER_CHKSUM_EN
          end else if (cnt_q == len_q) begin
            // payload done, checksum byte not yet sent
            state_d = CHK;
`endif
          end else begin
            state_d = STOP;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

`ifdef UART_FRAME_SER_CHKSUM_EN
      CHK: begin
        if (bus.TX_READY) begin
          start_out_d = 1'b1;
          data_out_d  = chk_q;
          cnt_d       = cnt_q + CNT_W'(1);
          tmr_d       = GAP_LOAD;
          state_d     = GAP;
        end
      end
`endif

      STOP: begin
        // BUSY stays up through the DONE cycle; START seen while DONE is
        // high is ignored because we are still in STOP.
        if (!done_q) begin
          done_d     = 1'b1;
          data_out_d = '0;
          cnt_d      = '0;
          tmr_d      = '0;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        buf_d      = '0;
        len_d      = '0;
        cnt_d      = '0;
        tmr_d      = '0;
        data_out_d = '0;
        busy_d     = 1'b0;
`ifdef UART_FRAME_SER_CHKSUM_EN
        chk_d      = '0;
`endif
      end
    endcase
  end

  assign bus.START_OUT = start_out_q;
  assign bus.DATA_OUT  = data_out_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.LEN_ERR   = len_err_q;

endmodule

// File: tb/tb_uart_frame_ser.sv
// tb_uart_frame_ser
//   Directed and randomized frames for uart_frame_ser (MAX_BYTES=12, LEN_W=4,
//   GAP_CYCLES=4). Expected strobe times come from the timing rules: a byte
//   goes out on the first ready edge at/after it becomes eligible; the next
//   byte becomes eligible GAP_CYCLES+1 edges later; DONE follows the last
//   byte by GAP_CYCLES+1 edges. Edge index 0 is the accepting edge.
module tb_uart_frame_ser;
  localparam int MAX_BYTES  = 12;
  localparam int LEN_W      = 4;
  localparam int GAP_CYCLES = 4;
  localparam int BUF_W      = 8 * MAX_BYTES;
  localparam int RDY_N      = 256;

  logic CLK;
  logic RST;
  int   cyc;
  int   total;
  int   bad;
  bit   rdy [RDY_N];

  uart_frame_ser_if #(.MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) bus ();

  uart_frame_ser #(
    .MAX_BYTES (MAX_BYTES),
    .LEN_W     (LEN_W),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rdy_at(input int k);
    return (k < RDY_N) ? rdy[k] : 1'b1;
  endfunction

  task automatic fill_rdy(input bit random_mode);
    for (int k = 0; k < RDY_N; k++)
      rdy[k] = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  function automatic logic [BUF_W-1:0] rand_payload();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic run_frame(input string tag, input int len, input logic [BUF_W-1:0] data,
                           input bit junk, output int o_first, output int o_second,
                           output int o_done);
    int         exp_t[$];
    logic [7:0] exp_d[$];
    int         obs_t[$];
    logic [7:0] obs_d[$];
    int         elig, s, exp_done, done_cnt, done_j, rise_j, fall_j, lerr_cnt, hold_err;
    logic [7:0] b, x, last_d;
    bit         busy_prev;

    elig = 1;
    x    = 8'h00;
    for (int i = 0; i < len; i++) begin
      b = data[BUF_W-1-8*i -: 8];
      s = elig;
      while (!rdy_at(s)) s++;
      exp_t.push_back(s);
      exp_d.push_back(b);
      x    = x ^ b;
      elig = s + GAP_CYCLES + 1;
    end
`ifdef UART_FRAME_SER_CHKSUM_EN
    s = elig;
    while (!rdy_at(s)) s++;
    exp_t.push_back(s);
    exp_d.push_back(x);
    elig = s + GAP_CYCLES + 1;
`endif
    exp_done = elig;

    @(negedge CLK);
    bus.START    = 1'b1;
    bus.LEN      = LEN_W'(len);
    bus.DATA_IN  = data;
    bus.TX_READY = rdy_at(0);
    @(negedge CLK);
    bus.START   = 1'b0;
    bus.LEN     = LEN_W'($urandom);
    bus.DATA_IN = rand_payload();

    done_cnt = 0; done_j = -1; rise_j = -1; fall_j = -1;
    lerr_cnt = 0; hold_err = 0; last_d = 8'h00; busy_prev = 1'b0;
    for (int j = 0; j <= exp_done + 3; j++) begin
      if (j > 0) @(negedge CLK);
      if (bus.START_OUT) begin
        obs_t.push_back(j);
        obs_d.push_back(bus.DATA_OUT);
        last_d = bus.DATA_OUT;
      end else if (bus.BUSY && !bus.DONE && (bus.DATA_OUT !== last_d)) begin
        hold_err++;
      end
      if (bus.DONE) begin
        done_cnt++;
        done_j = j;
      end
      if (bus.LEN_ERR) lerr_cnt++;
      if (bus.BUSY && !busy_prev && rise_j < 0) rise_j = j;
      if (!bus.BUSY && busy_prev && fall_j < 0) fall_j = j;
      busy_prev    = bus.BUSY;
      bus.TX_READY = rdy_at(j + 1);
      if (junk && (j + 1 <= exp_done + 1) && ($urandom_range(0, 3) == 0)) begin
        bus.START = 1'b1;
        bus.LEN   = LEN_W'($urandom);
      end else begin
        bus.START = 1'b0;
      end
    end
    bus.START = 1'b0;

    check({tag, " strobe_count"}, obs_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size(); i++) begin
      if (i < obs_t.size()) begin
        check($sformatf("%s byte%0d_time", tag, i), obs_t[i], exp_t[i]);
        check($sformatf("%s byte%0d_data", tag, i), {24'h0, obs_d[i]}, {24'h0, exp_d[i]});
      end
    end
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_time"}, done_j, exp_done);
    check({tag, " busy_rise"}, rise_j, 0);
    check({tag, " busy_fall"}, fall_j, exp_done + 1);
    check({tag, " len_err_count"}, lerr_cnt, 0);
    check({tag, " data_hold"}, hold_err, 0);
    check({tag, " data_out_after"}, {24'h0, bus.DATA_OUT}, 0);
    o_first  = (obs_t.size() > 0) ? obs_t[0] : -1;
    o_second = (obs_t.size() > 1) ? obs_t[1] : -1;
    o_done   = done_j;
  endtask

  task automatic len_err_case(input int l);
    int strobes, busys;
    @(negedge CLK);
    bus.START = 1'b1;
    bus.LEN   = LEN_W'(l);
    @(negedge CLK);
    bus.START = 1'b0;
    check($sformatf("len%0d len_err_pulse", l), bus.LEN_ERR, 1);
    check($sformatf("len%0d busy", l), bus.BUSY, 0);
    @(negedge CLK);
    check($sformatf("len%0d len_err_clear", l), bus.LEN_ERR, 0);
    strobes = 0; busys = 0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.START_OUT) strobes++;
      if (bus.BUSY) busys++;
    end
    check($sformatf("len%0d no_strobe", l), strobes, 0);
    check($sformatf("len%0d no_busy", l), busys, 0);
  endtask

  initial begin
    int f, sec, d;
    int strobes, dones, busys, l;
    logic [BUF_W-1:0] p;

    total = 0;
    bad   = 0;
    RST          = 1'b1;
    bus.START    = 1'b0;
    bus.LEN      = '0;
    bus.DATA_IN  = '0;
    bus.TX_READY = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset start_out", bus.START_OUT, 0);
    check("reset data_out", {24'h0, bus.DATA_OUT}, 0);
    check("reset busy", bus.BUSY, 0);
    check("reset done", bus.DONE, 0);
    check("reset len_err", bus.LEN_ERR, 0);
    RST = 1'b0;
    @(negedge CLK);

    // A5,3C,0F: strobes at spec cycles 2,7,12, DONE at 17 (edge index n-1)
    fill_rdy(1'b0);
    p = rand_payload();
    p[BUF_W-1 -: 24] = 24'hA53C0F;
    run_frame("basic3", 3, p, 1'b0, f, sec, d);
    check("basic3 first_strobe_cycle", f + 1, 2);
    check("basic3 second_strobe_cycle", sec + 1, 7);
    check("basic3 done_cycle", d + 1, 17);

    len_err_case(0);
    len_err_case(13);
    len_err_case(15);

    // TX_READY low for 20 SEND edges before byte 2
    fill_rdy(1'b0);
    for (int k = 2; k <= 25; k++) rdy[k] = 1'b0;
    run_frame("stall2", 2, rand_payload(), 1'b0, f, sec, d);
    check("stall2 delay", sec - (f + GAP_CYCLES + 1), 20);

    // reset during the gap after byte 1 of a 5-byte frame
    fill_rdy(1'b0);
    p = rand_payload();
    @(negedge CLK);
    bus.START   = 1'b1;
    bus.LEN     = LEN_W'(5);
    bus.DATA_IN = p;
    @(negedge CLK);
    bus.START = 1'b0;
    @(negedge CLK);
    check("rstmid byte0_strobe", bus.START_OUT, 1);
    check("rstmid byte0_data", {24'h0, bus.DATA_OUT}, {24'h0, p[BUF_W-1 -: 8]});
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rstmid start_out", bus.START_OUT, 0);
    check("rstmid data_out", {24'h0, bus.DATA_OUT}, 0);
    check("rstmid busy", bus.BUSY, 0);
    check("rstmid done", bus.DONE, 0);
    strobes = 0; dones = 0; busys = 0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.START_OUT) strobes++;
      if (bus.DONE) dones++;
      if (bus.BUSY) busys++;
    end
    check("rstmid later_strobes", strobes, 0);
    check("rstmid later_done", dones, 0);
    check("rstmid later_busy", busys, 0);
    run_frame("after_rst", 4, rand_payload(), 1'b0, f, sec, d);

    // reset wins over a simultaneous START
    @(negedge CLK);
    RST       = 1'b1;
    bus.START = 1'b1;
    bus.LEN   = LEN_W'(3);
    @(negedge CLK);
    RST       = 1'b0;
    bus.START = 1'b0;
    busys = 0;
    repeat (4) begin
      @(negedge CLK);
      if (bus.BUSY || bus.START_OUT) busys++;
    end
    check("rst_vs_start idle", busys, 0);

    // randomized frames: random length, payload, TX_READY stalls, junk START
    for (int n = 0; n < 6; n++) begin
      fill_rdy(1'b1);
      l = (n == 0) ? MAX_BYTES : ((n == 1) ? 1 : $urandom_range(1, MAX_BYTES));
      run_frame($sformatf("rand%0d", n), l, rand_payload(), 1'b1, f, sec, d);
    end

    for (int n = 0; n < 3; n++) begin
      l = $urandom_range(0, 3);
      len_err_case((l == 0) ? 0 : MAX_BYTES + l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_ser.md
UART_FRAME_SER -- requirements
Module: uart_frame_ser

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 12: maximum payload bytes per frame.
REQ-002 SHALL have parameter LEN_W, default 4: width of LEN; 2**LEN_W > MAX_BYTES.
REQ-003 SHALL have parameter GAP_CYCLES, default 4330: inter-byte spacing in clocks, legal range >= 1.
REQ-004 SHALL have port CLK  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port START  input  1  frame request, sampled only in IDLE.
REQ-007 SHALL have port LEN  input  LEN_W  payload byte count, sampled with START.
REQ-008 SHALL have port DATA_IN  input  8*MAX_BYTES  payload; byte 0 = DATA_IN[8*MAX_BYTES-1 -: 8], sent first.
REQ-009 SHALL have port TX_READY  input  1  downstream UART byte transmitter can accept a byte.
REQ-010 SHALL have port START_OUT  output  1  one-cycle byte strobe to the UART transmitter.
REQ-011 SHALL have port DATA_OUT  output  8  byte qualified by START_OUT.
REQ-012 SHALL have port BUSY  output  1  high from frame acceptance until DONE.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse after the last byte's gap expires.
REQ-014 SHALL have port LEN_ERR  output  1  one-cycle pulse on rejected request.

Function
REQ-015 SHALL register all outputs; no combinational input-to-output path.
REQ-016 SHALL implement states IDLE, SEND, GAP, CHK (macro only), STOP.
REQ-017 IDLE: START=1 with 1 <= LEN <= MAX_BYTES SHALL latch DATA_IN and LEN, set BUSY next cycle, go to SEND.
REQ-018 IDLE: START=1 with LEN=0 or LEN>MAX_BYTES SHALL pulse LEN_ERR one cycle, latch nothing, stay IDLE.
REQ-019 SEND with TX_READY=1 SHALL assert START_OUT for exactly one cycle with DATA_OUT = current top byte, shift the buffer left 8 bits, increment the sent count, load the gap timer with GAP_CYCLES-1, and go to GAP.
REQ-020 SEND with TX_READY=0 SHALL hold state, buffer and counters with START_OUT=0 (stall, unbounded).
REQ-021 GAP SHALL decrement the timer each cycle; at timer=0 it SHALL go to SEND if sent count < LEN, else CHK (macro) or STOP.
REQ-022 With TX_READY held high, first START_OUT SHALL appear 2 cycles after the accepting START edge and consecutive START_OUT pulses SHALL be exactly GAP_CYCLES+1 clocks apart.
REQ-023 STOP SHALL pulse DONE one cycle, clear BUSY, clear DATA_OUT to 0, clear counters, return to IDLE; a frame of LEN bytes yields exactly LEN strobes (plus 1 with macro).
REQ-024 DATA_OUT SHALL hold its value between strobes while BUSY.
REQ-025 START while BUSY SHALL be ignored: no LEN_ERR, frame unaffected, no queuing.
REQ-026 START in the cycle DONE is asserted SHALL be ignored; a new frame is accepted from the following IDLE cycle.
REQ-027 Sent count and gap timer SHALL be sized to hold MAX_BYTES+1 and GAP_CYCLES-1 without wrap.
REQ-028 Unreachable state encodings SHALL return to IDLE on the next clock with outputs at reset values.

Reset
REQ-029 RST=1 at a clock edge SHALL force IDLE, START_OUT=0, DATA_OUT=0, BUSY=0, DONE=0, LEN_ERR=0, counters and timer=0, in any state.
REQ-030 RST mid-frame SHALL abort the frame with no further START_OUT and no DONE pulse.
REQ-031 RST SHALL take priority over START in the same cycle.

Configuration
REQ-032 Macro UART_FRAME_SER_CHKSUM_EN defined SHALL add state CHK: after the last payload gap, on TX_READY=1 emit one extra strobe with DATA_OUT = XOR of all LEN payload bytes, then a full GAP, then STOP.
REQ-033 Macro undefined SHALL omit CHK and the checksum register; frame is exactly LEN bytes, timing otherwise identical.

Verification
REQ-034 Reset then START, LEN=3, DATA_IN top bytes A5,3C,0F, TX_READY=1, GAP_CYCLES=4 -> strobes A5,3C,0F at cycles 2,7,12; DONE at cycle 17; BUSY high cycles 1-17.
REQ-035 START with LEN=0, then LEN=13 (MAX_BYTES=12) -> one LEN_ERR pulse each, BUSY stays 0, no strobes.
REQ-036 TX_READY low for 20 cycles before byte 2 of a LEN=2 frame -> byte 2 strobe delayed exactly 20 cycles, data unchanged.
REQ-037 RST asserted during GAP after byte 1 of LEN=5 -> all outputs 0 next cycle, no further strobes, no DONE; next START accepted normally.
REQ-038 Macro defined, LEN=3 with bytes A5,3C,0F -> fourth strobe DATA_OUT=96 one GAP after 0F, DONE one GAP later; macro undefined -> 3 strobes only.
